// File: rtl/preset_clear_dff_bit.sv
// -----------------------------------------------------------------------------
// preset_clear_dff_bit
// Single-bit D register with an asynchronous active-low preset and a
// synchronous active-high clear. When PRESET_BIT is 0, the preset input
// acts as an asynchronous clear for this bit.
//
// Ports:
//   clk      - rising-edge clock
//   preset_n - async active-low preset; forces q to PRESET_BIT
//   clr      - sync active-high clear; q <= 0 on the edge
//   d        - data captured on the edge when clr is low
//   q        - registered output
// -----------------------------------------------------------------------------
module preset_clear_dff_bit #(
    parameter logic PRESET_BIT = 1'b1
) (
    input  logic clk,
    input  logic preset_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    // Priority: preset_n, then clr, then d. The preset branch also covers
    // an edge that coincides with preset_n release: preset_n is still seen
    // low, so q keeps the preset value until the following edge.
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            q <= PRESET_BIT;
        end else if (clr) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/preset_clear_dff.sv
// -----------------------------------------------------------------------------
// preset_clear_dff
// WIDTH-bit D register with asynchronous active-low preset to PRESET_VALUE
// and synchronous active-high clear. Built from WIDTH single-bit cells, each
// of which takes its preset level from the matching bit of PRESET_VALUE.
//
// Ports:
//   clk      - rising-edge clock
//   preset_n - async active-low preset (block reset); q = PRESET_VALUE
//   clr      - sync active-high clear; q <= 0
//   d        - data word captured on the rising edge
//   q        - registered output word
// -----------------------------------------------------------------------------
module preset_clear_dff #(
    parameter int                WIDTH        = 1,
    parameter logic [WIDTH-1:0]  PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             preset_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        preset_clear_dff_bit #(
            .PRESET_BIT (PRESET_VALUE[i])
        ) u_bit (
            .clk      (clk),
            .preset_n (preset_n),
            .clr      (clr),
            .d        (d[i]),
            .q        (q[i])
        );
    end

endmodule

// File: tb/tb_preset_clear_dff.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_preset_clear_dff
// Directed vectors on a 10 ns clock (rising edges at 5, 15, 25, ... ns).
// A 1-bit instance (PRESET_VALUE=1) follows the test plan; a 4-bit instance
// with a mixed preset pattern shares the controls so per-bit preset levels
// are exercised too. Stimulus pushes hand-computed expectations into a
// queue and fires a sample event; a separate monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_preset_clear_dff;

    localparam logic [3:0] PV4 = 4'b1010;

    typedef struct {
        logic       q1;
        logic [3:0] q4;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       preset_n;
    logic       clr;
    logic       d;
    logic [3:0] d4;
    logic       q;
    logic [3:0] q4;

    exp_t exp_q[$];
    event sample_ev;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    preset_clear_dff #(
        .WIDTH        (1),
        .PRESET_VALUE (1'b1)
    ) u_dut (
        .clk      (clk),
        .preset_n (preset_n),
        .clr      (clr),
        .d        (d),
        .q        (q)
    );

    preset_clear_dff #(
        .WIDTH        (4),
        .PRESET_VALUE (PV4)
    ) u_dut4 (
        .clk      (clk),
        .preset_n (preset_n),
        .clr      (clr),
        .d        (d4),
        .q        (q4)
    );

    // Monitor: one comparison per sample event.
    initial begin
        forever begin
            @(sample_ev);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sample with empty scoreboard at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (q !== e.q1 || q4 !== e.q4) begin
                    n_fail++;
                    $display("FAIL %s @%0t: q=%b q4=%b, expected q=%b q4=%b",
                             e.name, $time, q, q4, e.q1, e.q4);
                end
            end
        end
    end

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    // Queue the expectation, wake the monitor, then step off the timestep.
    task automatic expect_at(input time t, input logic e1, input logic [3:0] e4,
                             input string name);
        exp_t e;
        wait_until(t);
        e.q1 = e1;
        e.q4 = e4;
        e.name = name;
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    initial begin
        preset_n = 1'b1;
        clr      = 1'b0;
        d        = 1'b0;
        d4       = 4'h0;

        // Clock the register first so q is defined (edges 5, 15).
        expect_at(16, 1'b0, 4'h0, "first_capture");

        // Async preset between edges.
        wait_until(18); preset_n = 1'b0;
        expect_at(19, 1'b1, PV4, "async_preset");

        // Release between edges: hold preset value until edge 25.
        wait_until(23); preset_n = 1'b1;
        expect_at(24, 1'b1, PV4, "hold_after_release");
        expect_at(26, 1'b0, 4'h0, "capture_after_release");

        // Tracking d across edges 35, 45, 55, 65.
        wait_until(30); d = 1'b1; d4 = 4'h5;
        expect_at(31, 1'b0, 4'h0, "d_change_between_edges");
        expect_at(36, 1'b1, 4'h5, "track0");
        wait_until(40); d = 1'b0; d4 = 4'h3;
        expect_at(46, 1'b0, 4'h3, "track1");
        wait_until(50); d = 1'b0; d4 = 4'hc;
        expect_at(56, 1'b0, 4'hc, "track2");
        wait_until(60); d = 1'b1; d4 = 4'hf;
        expect_at(66, 1'b1, 4'hf, "track3");

        // Sync clear at edge 75, with d high.
        wait_until(70); clr = 1'b1; d = 1'b1; d4 = 4'h6;
        expect_at(71, 1'b1, 4'hf, "clr_before_edge");
        expect_at(76, 1'b0, 4'h0, "sync_clear");
        wait_until(86); clr = 1'b0;
        expect_at(88, 1'b0, 4'h0, "clr_drop_midcycle");
        expect_at(96, 1'b1, 4'h6, "capture_after_clr");

        // Preset pulse while clr is held high.
        wait_until(100); clr = 1'b1; d = 1'b1; d4 = 4'h9;
        expect_at(106, 1'b0, 4'h0, "clear_before_pulse");
        wait_until(107); preset_n = 1'b0;
        expect_at(108, 1'b1, PV4, "preset_over_clear");
        wait_until(112); preset_n = 1'b1;
        expect_at(113, 1'b1, PV4, "pulse_released_hold");
        expect_at(116, 1'b0, 4'h0, "clear_after_pulse");

        // Release exactly on the edge at 125. The NBA update keeps the
        // release strictly after the register's evaluation of that edge.
        wait_until(120); clr = 1'b0; d = 1'b0; d4 = 4'h3; preset_n = 1'b0;
        expect_at(121, 1'b1, PV4, "preset_before_edge_release");
        wait_until(125); preset_n <= 1'b1;
        expect_at(126, 1'b1, PV4, "edge_release_ignored");
        expect_at(136, 1'b0, 4'h3, "capture_after_edge_release");

        // Short preset glitch between edges is not filtered.
        wait_until(140); preset_n = 1'b0;
        #0.5 preset_n = 1'b1;
        expect_at(142, 1'b1, PV4, "glitch_preset");
        d4 = 4'h1;
        expect_at(146, 1'b0, 4'h1, "capture_after_glitch");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
